inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameters (name, default, meaning): col 8 array columns; row 8 array rows; len_nij 36 input pixels; len_kij 9 kernel taps; in_w 6 input width; k_w 3 kernel width; o_w = in_w-k_w+1 = 4 output width; len_onij = o_w*o_w = 16; rst_cyc 2 core reset cycles.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run the full conv sequence; honored only in IDLE.
REQ-005 ofifo_valid  input  1  core OFIFO has a readable entry.
REQ-006 inst  output  35  registered core instruction: [34] mode (always 0), [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-007 core_rst  output  1  registered reset to core datapath.
REQ-008 busy  output  1  high outside IDLE.
REQ-009 out_valid  output  1  one-cycle pulse: core sfp_out holds output out_idx.
REQ-010 out_idx  output  4  output pixel index 0..len_onij-1.
REQ-011 done  output  1  one-cycle pulse when sequence ends.

Function
REQ-012 Idle inst value: CEN/WEN bits 1, all addresses 0, all other bits 0; every state not naming a bit drives it idle.
REQ-013 Preloaded memory map: activations xmem 0..len_nij-1; weights for tap k at xmem 1024+k*col .. +col-1; psum for tap k, pixel n written to pmem k*len_nij+n.
REQ-014 States: IDLE, KRST, W_L0, W_PE, GAP, X_L0, EXEC, DRAIN, ARST, ACC, AFLUSH, AOUT, DONE.
REQ-015 IDLE->KRST on start; kij counter cleared.
REQ-016 KRST: core_rst=1 for rst_cyc cycles -> W_L0.
REQ-017 W_L0: col cycles, CEN_xmem=0, WEN_xmem=1, l0_wr=1, A_xmem=1024+kij*col+i -> W_PE.
REQ-018 W_PE: 1 cycle l0_rd=1 only, then col cycles l0_rd=1 load=1 -> GAP (1 idle cycle) -> X_L0.
REQ-019 X_L0: len_nij cycles, CEN_xmem=0, WEN_xmem=1, l0_wr=1, A_xmem=i -> EXEC.
REQ-020 EXEC: 1 cycle l0_rd=1, then len_nij+row+col cycles l0_rd=1 execute=1 -> DRAIN.
REQ-021 DRAIN: per cycle with ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=kij*len_nij+n, n increments; ofifo_valid=0 -> idle inst, n held (stall, no timeout).
REQ-022 After len_nij writes: kij<len_kij-1 -> kij+1, KRST; else o=0, ARST.
REQ-023 ARST: core_rst=1 for 1 cycle -> ACC.
REQ-024 ACC: len_kij cycles, tap k=ki*k_w+kj: CEN_pmem=0, WEN_pmem=1, A_pmem=k*len_nij+((o/o_w)+ki)*in_w+(o%o_w)+kj; acc=1 on cycles 1..len_kij-1 of ACC and in the single AFLUSH cycle (pmem 1-cycle read latency).
REQ-025 AFLUSH -> AOUT: 1 idle cycle, then out_valid=1, out_idx=o; o<len_onij-1 -> o+1, ARST; else DONE.
REQ-026 DONE: done=1 one cycle -> IDLE.
REQ-027 start while busy ignored; ififo_wr, ififo_rd, mode always 0.
REQ-028 Address arithmetic 11-bit unsigned, no wrap for default parameters (max pmem 8*36+35=323).

Reset
REQ-029 reset asserted asynchronously forces IDLE, inst idle value, core_rst=1, busy=0, out_valid=0, out_idx=0, done=0, all counters 0; core_rst drops on first clock after release.
REQ-030 reset mid-sequence aborts with no further pmem/xmem activity; next start restarts at kij=0.

Verification
REQ-031 Reset then 5 idle cycles -> inst=idle value, busy=0, core_rst 1 during reset only.
REQ-032 start, ofifo_valid tied 1 -> kij=2 W_L0 A_xmem 1040..1047; per-kij 145 cycles; DRAIN writes A_pmem 72..107 for kij=2.
REQ-033 ofifo_valid low 4 cycles mid-DRAIN at n=10 -> 4 idle cycles, next write A_pmem=kij*36+10, total writes still 36.
REQ-034 ACC o=5 -> A_pmem sequence 7,44,81,121,158,195,235,272,309; acc high 9 cycles.
REQ-035 Full run -> 16 out_valid pulses out_idx 0..15, then one done pulse, busy low; start during busy changes nothing.
REQ-036 reset during EXEC of kij=4 -> immediate idle inst; new start -> W_L0 from A_xmem 1024.

Source files
------------

// File: rtl/inst_sequencer_if.sv
// ----------------------------------------------------------------------------
// inst_sequencer_if
// Groups the sequencer control/status signals. The sequencer uses the slave
// modport; whoever drives start and reports OFIFO state uses master.
//   start        request to run the full convolution sequence
//   ofifo_valid  core OFIFO has a readable entry
//   inst         35-bit core instruction word
//   core_rst     reset to the core datapath
//   busy         sequencer is not idle
//   out_valid    sfp_out holds output pixel out_idx (one-cycle pulse)
//   out_idx      output pixel index
//   done         one-cycle pulse at end of sequence
// ----------------------------------------------------------------------------
interface inst_sequencer_if #(
  parameter int idx_w = 4
);
  logic              start;
  logic              ofifo_valid;
  logic [34:0]       inst;
  logic              core_rst;
  logic              busy;
  logic              out_valid;
  logic [idx_w-1:0]  out_idx;
  logic              done;

  modport slave (
    input  start, ofifo_valid,
    output inst, core_rst, busy, out_valid, out_idx, done
  );

  modport master (
    output start, ofifo_valid,
    input  inst, core_rst, busy, out_valid, out_idx, done
  );
endinterface

// File: rtl/inst_sequencer.sv
// ----------------------------------------------------------------------------
// inst_sequencer
// Drives the systolic conv core through a full convolution: for every kernel
// tap it loads weights, streams activations, executes and drains partial sums
// into pmem; it then accumulates the taps per output pixel and flags each
// result on sfp_out.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    inst_sequencer_if.slave (start/ofifo_valid in; inst, core_rst,
//          busy, out_valid, out_idx, done out)
//
// state  | meaning
// IDLE   | waiting for start
// KRST   | core reset before each kernel tap
// W_L0   | weights for tap kij, xmem -> L0
// W_PE   | L0 -> PE weight load (1 read-only cycle, then col load cycles)
// GAP    | one idle cycle between weight load and activation load
// X_L0   | activations, xmem -> L0
// EXEC   | 1 read-only cycle, then len_nij+row+col execute cycles
// DRAIN  | OFIFO -> pmem psum writes, stalls while OFIFO is empty
// ARST   | core reset before accumulating output pixel o
// ACC    | read the len_kij psums of pixel o, accumulating from cycle 1
// AFLUSH | last accumulate for the final pmem read (1-cycle read latency)
// AOUT   | pixel o valid on sfp_out
// DONE   | completion pulse
// ----------------------------------------------------------------------------
module inst_sequencer #(
  parameter int col      = 8,
  parameter int row      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int in_w     = 6,
  parameter int k_w      = 3,
  parameter int o_w      = in_w - k_w + 1,
  parameter int len_onij = o_w * o_w,
  parameter int rst_cyc  = 2
) (
  input  logic              clk,
  input  logic              reset,
  inst_sequencer_if.slave   bus
);

  localparam int TW  = $clog2(len_nij + row + col + 1);
  localparam int KJW = $clog2(len_kij);
  localparam int NW  = $clog2(len_nij);
  localparam int OW  = $clog2(len_onij);
  localparam int XW  = $clog2(o_w);
  localparam int KW  = $clog2(k_w);

  // CEN/WEN high, everything else low
  localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_KRST, S_W_L0, S_W_PE, S_GAP, S_X_L0, S_EXEC,
    S_DRAIN, S_ARST, S_ACC, S_AFLUSH, S_AOUT, S_DONE
  } state_t;

  state_t           r_state, w_state_nx;
  logic [TW-1:0]    r_tmr,   w_tmr_nx;
  logic [KJW-1:0]   r_kij,   w_kij_nx;
  logic [NW-1:0]    r_n,     w_n_nx;
  logic [OW-1:0]    r_o,     w_o_nx;
  logic [XW-1:0]    r_oy,    w_oy_nx;
  logic [XW-1:0]    r_ox,    w_ox_nx;
  logic [KW-1:0]    r_ki,    w_ki_nx;
  logic [KW-1:0]    r_kj,    w_kj_nx;

  logic [34:0]      r_inst;
  logic             r_core_rst;
  logic             r_out_valid;
  logic [OW-1:0]    r_out_idx;
  logic             r_done;

  logic             w_acc, w_cen_p, w_wen_p, w_cen_x, w_wen_x;
  logic [10:0]      w_a_p, w_a_x;
  logic             w_ofifo_rd, w_l0_rd, w_l0_wr, w_execute, w_load;
  logic             w_core_rst, w_out_valid, w_done;
  logic [OW-1:0]    w_out_idx;
  logic [34:0]      w_inst;

  logic [10:0]      w_a_wl, w_a_xl, w_a_dr, w_a_acc;

  // Timers count down, so the element index within a burst is (len-1 - tmr).
  assign w_a_wl  = 11'(1024 + int'(r_kij) * col + (col - 1) - int'(r_tmr));
  assign w_a_xl  = 11'((len_nij - 1) - int'(r_tmr));
  assign w_a_dr  = 11'(int'(r_kij) * len_nij + int'(r_n));
  assign w_a_acc = 11'((int'(r_ki) * k_w + int'(r_kj)) * len_nij
                       + (int'(r_oy) + int'(r_ki)) * in_w
                       + int'(r_ox) + int'(r_kj));

  assign w_inst = {1'b0, w_acc, w_cen_p, w_wen_p, w_a_p,
                   w_cen_x, w_wen_x, w_a_x,
                   w_ofifo_rd, 1'b0, 1'b0, w_l0_rd, w_l0_wr, w_execute, w_load};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_kij       <= '0;
      r_n         <= '0;
      r_o         <= '0;
      r_oy        <= '0;
      r_ox        <= '0;
      r_ki        <= '0;
      r_kj        <= '0;
      r_inst      <= IDLE_INST;
      r_core_rst  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_tmr       <= w_tmr_nx;
      r_kij       <= w_kij_nx;
      r_n         <= w_n_nx;
      r_o         <= w_o_nx;
      r_oy        <= w_oy_nx;
      r_ox        <= w_ox_nx;
      r_ki        <= w_ki_nx;
      r_kj        <= w_kj_nx;
      r_inst      <= w_inst;
      r_core_rst  <= w_core_rst;
      r_out_valid <= w_out_valid;
      r_out_idx   <= w_out_idx;
      r_done      <= w_done;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_tmr_nx    = r_tmr;
    w_kij_nx    = r_kij;
    w_n_nx      = r_n;
    w_o_nx      = r_o;
    w_oy_nx     = r_oy;
    w_ox_nx     = r_ox;
    w_ki_nx     = r_ki;
    w_kj_nx     = r_kj;
    w_acc       = 1'b0;
    w_cen_p     = 1'b1;
    w_wen_p     = 1'b1;
    w_a_p       = '0;
    w_cen_x     = 1'b1;
    w_wen_x     = 1'b1;
    w_a_x       = '0;
    w_ofifo_rd  = 1'b0;
    w_l0_rd     = 1'b0;
    w_l0_wr     = 1'b0;
    w_execute   = 1'b0;
    w_load      = 1'b0;
    w_core_rst  = 1'b0;
    w_out_valid = 1'b0;
    w_out_idx   = r_out_idx;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nx = S_KRST;
          w_kij_nx   = '0;
          w_tmr_nx   = TW'(rst_cyc - 1);
        end
      end

      S_KRST: begin
        w_core_rst = 1'b1;
        if (r_tmr == '0) begin
          w_state_nx = S_W_L0;
          w_tmr_nx   = TW'(col - 1);
        end else begin
          w_tmr_nx = r_tmr - 1'b1;
        end
      end

      S_W_L0: begin
        w_cen_x = 1'b0;
        w_l0_wr = 1'b1;
        w_a_x   = w_a_wl;
        if (r_tmr == '0) begin
          w_state_nx = S_W_PE;
          w_tmr_nx   = TW'(col);
        end else begin
          w_tmr_nx = r_tmr - 1'b1;
        end
      end

      S_W_PE: begin
        w_l0_rd = 1'b1;
        w_load  = (r_tmr != TW'(col));   // first cycle only primes the L0 read
        if (r_tmr == '0) begin
          w_state_nx = S_GAP;
        end else begin
          w_tmr_nx = r_tmr - 1'b1;
        end
      end

      S_GAP: begin
        w_state_nx = S_X_L0;
        w_tmr_nx   = TW'(len_nij - 1);
      end

      S_X_L0: begin
        w_cen_x = 1'b0;
        w_l0_wr = 1'b1;
        w_a_x   = w_a_xl;
        if (r_tmr == '0) begin
          w_state_nx = S_EXEC;
          w_tmr_nx   = TW'(len_nij + row + col);
        end else begin
          w_tmr_nx = r_tmr - 1'b1;
        end
      end

      S_EXEC: begin
        w_l0_rd   = 1'b1;
        w_execute = (r_tmr != TW'(len_nij + row + col));
        if (r_tmr == '0) begin
          w_state_nx = S_DRAIN;
          w_n_nx     = '0;
        end else begin
          w_tmr_nx = r_tmr - 1'b1;
        end
      end

      S_DRAIN: begin
        if (bus.ofifo_valid) begin
          w_ofifo_rd = 1'b1;
          w_cen_p    = 1'b0;
          w_wen_p    = 1'b0;
          w_a_p      = w_a_dr;
          if (r_n == NW'(len_nij - 1)) begin
            w_n_nx = '0;
            if (r_kij < KJW'(len_kij - 1)) begin
              w_kij_nx   = r_kij + 1'b1;
              w_state_nx = S_KRST;
              w_tmr_nx   = TW'(rst_cyc - 1);
            end else begin
              w_o_nx     = '0;
              w_oy_nx    = '0;
              w_ox_nx    = '0;
              w_state_nx = S_ARST;
            end
          end else begin
            w_n_nx = r_n + 1'b1;
          end
        end
      end

      S_ARST: begin
        w_core_rst = 1'b1;
        w_ki_nx    = '0;
        w_kj_nx    = '0;
        w_state_nx = S_ACC;
      end

      S_ACC: begin
        w_cen_p = 1'b0;
        w_a_p   = w_a_acc;
        // first read has no data back yet, so nothing to accumulate
        w_acc   = (r_ki != '0) || (r_kj != '0);
        if (r_kj == KW'(k_w - 1)) begin
          w_kj_nx = '0;
          if (r_ki == KW'(k_w - 1)) begin
            w_ki_nx    = '0;
            w_state_nx = S_AFLUSH;
          end else begin
            w_ki_nx = r_ki + 1'b1;
          end
        end else begin
          w_kj_nx = r_kj + 1'b1;
        end
      end

      S_AFLUSH: begin
        w_acc      = 1'b1;
        w_state_nx = S_AOUT;
      end

      S_AOUT: begin
        w_out_valid = 1'b1;
        w_out_idx   = r_o;
        if (r_o == OW'(len_onij - 1)) begin
          w_state_nx = S_DONE;
        end else begin
          w_o_nx     = r_o + 1'b1;
          w_state_nx = S_ARST;
          if (r_ox == XW'(o_w - 1)) begin
            w_ox_nx = '0;
            w_oy_nx = r_oy + 1'b1;
          end else begin
            w_ox_nx = r_ox + 1'b1;
          end
        end
      end

      S_DONE: begin
        w_done     = 1'b1;
        w_state_nx = S_IDLE;
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.inst      = r_inst;
  assign bus.core_rst  = r_core_rst;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = r_out_idx;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_inst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_inst_sequencer
// Scoreboard bench: the stimulus side pushes expected xmem reads, pmem
// writes, pmem reads and output indices; a monitor pops and compares each
// time the instruction word or status outputs show the matching event.
// ----------------------------------------------------------------------------
module tb_inst_sequencer;

  localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_sequencer_if bus ();

  inst_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int q_xrd[$];
  int q_pwr[$];
  int q_prd[$];
  int q_out[$];
  int wl_cyc[$];

  int cyc = 0;
  int done_cnt = 0;
  int wl_cnt = 0;
  int exec_cnt = 0;
  int last_pwr_addr = -1;
  int last_pwr_cyc = 0;
  bit stall_run = 1'b0;
  int t_load, t_exec, t_l0rd, t_l0wr, t_ofrd, t_acc, t_crst, t_bad;

  // hand-computed psum read order for output pixel 5
  int acc5[9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      logic [34:0] v;
      int a_p, a_x;
      @(negedge clk);
      cyc++;
      if (!reset) begin
        v   = bus.inst;
        a_p = int'(v[30:20]);
        a_x = int'(v[17:7]);
        if (v[34] | v[5] | v[4]) t_bad++;
        if (v[33]) t_acc++;
        if (v[6])  t_ofrd++;
        if (v[3])  t_l0rd++;
        if (v[2])  t_l0wr++;
        if (v[1])  begin t_exec++; exec_cnt++; end
        if (v[0])  t_load++;
        if (bus.core_rst) t_crst++;
        if (!v[19]) begin
          if (!v[18]) t_bad++;
          if (a_x >= 1024 && ((a_x - 1024) % 8) == 0) begin
            wl_cnt++;
            wl_cyc.push_back(cyc);
            exec_cnt = 0;
          end
          if (q_xrd.size() == 0) check("xmem_rd_unexpected", a_x, -1);
          else                   check("xmem_rd_addr", a_x, q_xrd.pop_front());
        end
        if (!v[32] && !v[31]) begin
          if (!v[6]) t_bad++;
          if (stall_run && a_p == 46) check("drain_stall_gap", cyc - last_pwr_cyc, 5);
          last_pwr_addr = a_p;
          last_pwr_cyc  = cyc;
          if (q_pwr.size() == 0) check("pmem_wr_unexpected", a_p, -1);
          else                   check("pmem_wr_addr", a_p, q_pwr.pop_front());
        end
        if (!v[32] && v[31]) begin
          if (q_prd.size() == 0) check("pmem_rd_unexpected", a_p, -1);
          else                   check("pmem_rd_addr", a_p, q_prd.pop_front());
        end
        if (bus.out_valid) begin
          if (q_out.size() == 0) check("out_unexpected", bus.out_idx, -1);
          else                   check("out_idx", bus.out_idx, q_out.pop_front());
        end
        if (bus.done) done_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_tallies();
    t_load = 0; t_exec = 0; t_l0rd = 0; t_l0wr = 0;
    t_ofrd = 0; t_acc = 0; t_crst = 0; t_bad = 0;
    done_cnt = 0; wl_cnt = 0; exec_cnt = 0;
    wl_cyc.delete();
  endtask

  task automatic clear_queues();
    q_xrd.delete(); q_pwr.delete(); q_prd.delete(); q_out.delete();
  endtask

  task automatic push_expected();
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++)  q_xrd.push_back(1024 + k * 8 + i);
      for (int i = 0; i < 36; i++) q_xrd.push_back(i);
      for (int n = 0; n < 36; n++) q_pwr.push_back(k * 36 + n);
    end
    for (int o = 0; o < 16; o++) begin
      for (int ki = 0; ki < 3; ki++)
        for (int kj = 0; kj < 3; kj++)
          if (o == 5) q_prd.push_back(acc5[ki * 3 + kj]);
          else        q_prd.push_back((ki * 3 + kj) * 36 + ((o / 4) + ki) * 6 + (o % 4) + kj);
      q_out.push_back(o);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic run_full(input bit stall, input bit poke);
    int scnt;
    bit stalled;
    scnt = 0;
    stalled = 1'b0;
    clear_tallies();
    stall_run = stall;
    push_expected();
    pulse_start();
    for (int c = 0; c < 6000 && done_cnt == 0; c++) begin
      @(negedge clk); #1;
      if (c == 10) check("busy_running", bus.busy, 1);
      if (poke && c == 400) bus.start = 1'b1;
      if (poke && c == 401) bus.start = 1'b0;
      if (stall && !stalled && last_pwr_addr == 45 && last_pwr_cyc == cyc) begin
        bus.ofifo_valid = 1'b0;
        scnt = 4;
        stalled = 1'b1;
      end else if (scnt > 0) begin
        scnt--;
        if (scnt == 0) bus.ofifo_valid = 1'b1;
      end
    end
    check("done_seen", done_cnt, 1);
    bus.ofifo_valid = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("done_single_pulse", done_cnt, 1);
    check("busy_after_done", bus.busy, 0);
    check("inst_idle_after_done", bus.inst, IDLE_INST);
    check("xrd_left", q_xrd.size(), 0);
    check("pwr_left", q_pwr.size(), 0);
    check("prd_left", q_prd.size(), 0);
    check("out_left", q_out.size(), 0);
    check("load_cycles", t_load, 72);
    check("execute_cycles", t_exec, 468);
    check("l0_rd_cycles", t_l0rd, 558);
    check("l0_wr_cycles", t_l0wr, 396);
    check("ofifo_rd_cycles", t_ofrd, 324);
    check("acc_cycles", t_acc, 144);
    check("core_rst_cycles", t_crst, 34);
    check("fixed_bits_bad", t_bad, 0);
    check("weight_loads", wl_cyc.size(), 9);
    if (wl_cyc.size() == 9)
      for (int k = 1; k < 9; k++)
        check("kij_period", wl_cyc[k] - wl_cyc[k - 1], (stall && k == 2) ? 149 : 145);
    stall_run = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    bus.start       = 1'b0;
    bus.ofifo_valid = 1'b1;
    reset           = 1'b1;
    clear_tallies();
    repeat (3) @(negedge clk);
    check("rst_inst", bus.inst, IDLE_INST);
    check("rst_core_rst", bus.core_rst, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("core_rst_released", bus.core_rst, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_inst", bus.inst, IDLE_INST);
      check("idle_busy", bus.busy, 0);
    end

    // full run with OFIFO always ready and a start while busy
    run_full(1'b0, 1'b1);

    // full run with a 4-cycle OFIFO stall at kij=1, n=10
    run_full(1'b1, 1'b0);

    // abort in EXEC of kij=4, then restart from kij=0
    clear_tallies();
    push_expected();
    pulse_start();
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 3000 && !hit; c++) begin
        @(negedge clk); #1;
        if (wl_cnt == 5 && exec_cnt > 10) hit = 1'b1;
      end
      check("reached_exec_kij4", hit, 1);
    end
    #1 reset = 1'b1;
    #1;
    check("abort_inst", bus.inst, IDLE_INST);
    check("abort_busy", bus.busy, 0);
    check("abort_core_rst", bus.core_rst, 1);
    check("abort_out_valid", bus.out_valid, 0);
    clear_queues();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("post_abort_inst", bus.inst, IDLE_INST);
    check("post_abort_busy", bus.busy, 0);
    run_full(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
